// File: rtl/fir_channel_scheduler_if.sv
// Channel sample / coefficient / result bundle for fir_channel_scheduler.
// master drives samples and coefficients, slave is the scheduler.
interface fir_channel_scheduler_if #(
   parameter int N   = 16,
   parameter int NCH = 4
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic               en;
   logic [NCH-1:0]     ch_valid;
   logic [NCH*N-1:0]   ch_data;
   logic [NCH-1:0]     ch_ready;
   logic               coef_wr;
   logic [N-1:0]       b0_in;
   logic [N-1:0]       b1_in;
   logic               y_valid;
   logic [N-1:0]       y_data;
   logic [CW-1:0]      y_ch;
   logic               busy;

   modport master (
      output en, ch_valid, ch_data, coef_wr, b0_in, b1_in,
      input  ch_ready, y_valid, y_data, y_ch, busy
   );

   modport slave (
      input  en, ch_valid, ch_data, coef_wr, b0_in, b1_in,
      output ch_ready, y_valid, y_data, y_ch, busy
   );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Shared symmetric 4-tap FIR (b0,b1,b1,b0) time-multiplexed over NCH channels.
// Round-robin grant, per-channel delay lines, one multiply per cycle, and
// shadow coefficients captured at accept so a pass never sees a mid-pass write.
module fir_channel_scheduler #(
   parameter int N     = 16,
   parameter int NCH   = 4,
   parameter int SHIFT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   fir_channel_scheduler_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW = 2 * N + 2;

   typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

   state_t                  state, state_next;
   logic [1:0]              tap;
   logic [CW-1:0]           rr, grant, cur_ch;
   logic [CW:0]             idx;
   logic                    found, accept;
   logic [NCH-1:0][N-1:0]   samples;
   logic [NCH-1:0][N-1:0]   h1, h2, h3;
   logic [N-1:0]            b0_sh, b1_sh, wb0, wb1;
   logic [N-1:0]            x0, w1, w2, w3;
   logic [N-1:0]            mul_a, mul_b;
   logic [2*N-1:0]          prod;
   logic [AW-1:0]           acc, acc_sum;

   assign samples  = bus.ch_data;
   assign bus.busy = (state == MAC);

   // Round-robin search: first valid channel at or after rr, wrapping
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = {1'b0, rr} + (CW+1)'(i);
         if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
         if (!found && bus.ch_valid[idx[CW-1:0]]) begin
            found = 1'b1;
            grant = idx[CW-1:0];
         end
      end
   end

   // Next state and accept strobe; ready only in IDLE with en and out of reset
   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      bus.ch_ready = '0;
      case (state)
         IDLE: if (bus.en && found && !rst) begin
            accept              = 1'b1;
            bus.ch_ready[grant] = 1'b1;
            state_next          = MAC;
         end
         MAC:  if (bus.en && tap == 2'd3) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Tap operand select and running sum including this cycle's product
   always_comb begin
      mul_a = x0;
      mul_b = wb0;
      case (tap)
         2'd1:    begin mul_a = w1; mul_b = wb1; end
         2'd2:    begin mul_a = w2; mul_b = wb1; end
         2'd3:    begin mul_a = w3; mul_b = wb0; end
         default: ;
      endcase
      prod    = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
      acc_sum = acc + AW'(prod);
   end

   // State, datapath, histories and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tap         <= '0;
         rr          <= '0;
         cur_ch      <= '0;
         h1          <= '0;
         h2          <= '0;
         h3          <= '0;
         b0_sh       <= '0;
         b1_sh       <= '0;
         wb0         <= '0;
         wb1         <= '0;
         x0          <= '0;
         w1          <= '0;
         w2          <= '0;
         w3          <= '0;
         acc         <= '0;
         bus.y_valid <= 1'b0;
         bus.y_data  <= '0;
         bus.y_ch    <= '0;
      end else begin
         state       <= state_next;
         bus.y_valid <= 1'b0;
         if (bus.coef_wr) begin
            b0_sh <= bus.b0_in;
            b1_sh <= bus.b1_in;
         end
         if (accept) begin
            // working coefs take the shadow value before any coincident write
            x0     <= samples[grant];
            w1     <= h1[grant];
            w2     <= h2[grant];
            w3     <= h3[grant];
            wb0    <= b0_sh;
            wb1    <= b1_sh;
            acc    <= '0;
            tap    <= '0;
            cur_ch <= grant;
            rr     <= (grant == CW'(NCH-1)) ? '0 : grant + CW'(1);
         end else if (state == MAC && bus.en) begin
            acc <= acc_sum;
            tap <= tap + 2'd1;
            if (tap == 2'd3) begin
               bus.y_data  <= acc_sum[SHIFT +: N];
               bus.y_ch    <= cur_ch;
               bus.y_valid <= 1'b1;
               h3[cur_ch]  <= h2[cur_ch];
               h2[cur_ch]  <= h1[cur_ch];
               h1[cur_ch]  <= x0;
            end
         end
      end
   end
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: impulse, round-robin, coefficient
// timing, en stall, reset mid-pass and truncation, with immediate assertions.
module tb_fir_channel_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   int   cyc = 0;

   fir_channel_scheduler_if #(.N(16), .NCH(4)) bus ();

   fir_channel_scheduler #(.N(16), .NCH(4), .SHIFT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_coef(input logic [15:0] b0, input logic [15:0] b1);
      bus.coef_wr = 1'b1;
      bus.b0_in   = b0;
      bus.b1_in   = b1;
      tick();
      bus.coef_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One pass on a single channel. stall: en=0 cycles starting in tap 1.
   // co_wr: coef write coincident with accept; mid_wr: coef write in tap 0.
   task automatic do_pass(input int ch, input logic [15:0] x, input int stall,
                          input bit co_wr, input bit mid_wr,
                          input logic [15:0] nb0, input logic [15:0] nb1,
                          output logic [15:0] y, output int ych, output int lat);
      int left;
      left = stall;
      bus.ch_valid = 4'(1 << ch);
      bus.ch_data[ch*16 +: 16] = x;
      if (co_wr) begin
         bus.coef_wr = 1'b1;
         bus.b0_in   = nb0;
         bus.b1_in   = nb1;
      end
      #1;
      check("ready", 32'(bus.ch_ready), 32'(1 << ch));
      tick();
      lat = 1;
      bus.ch_valid = '0;
      bus.coef_wr  = 1'b0;
      check("busy", 32'(bus.busy), 32'd1);
      while (!bus.y_valid && lat < 30) begin
         bus.coef_wr = 1'b0;
         bus.en      = 1'b1;
         if (lat == 1 && mid_wr) begin
            bus.coef_wr = 1'b1;
            bus.b0_in   = nb0;
            bus.b1_in   = nb1;
         end
         if (lat >= 2 && left > 0) begin
            bus.en = 1'b0;
            left--;
         end
         tick();
         lat++;
      end
      bus.en      = 1'b1;
      bus.coef_wr = 1'b0;
      check("y_valid_seen", 32'(bus.y_valid), 32'd1);
      y   = bus.y_data;
      ych = int'(bus.y_ch);
   endtask

   function automatic logic [15:0] fir(input logic [15:0] x, input logic [15:0] a1,
                                       input logic [15:0] a2, input logic [15:0] a3,
                                       input logic [15:0] b0, input logic [15:0] b1);
      logic [63:0] s;
      s = 64'(x) * 64'(b0) + 64'(a1) * 64'(b1) + 64'(a2) * 64'(b1) + 64'(a3) * 64'(b0);
      s = s >> 4;
      return s[15:0];
   endfunction

   logic [15:0] y;
   int          ych, lat;
   logic [15:0] imp_exp [5];
   logic [15:0] imp_in  [5];
   logic [15:0] mh1 [4];
   logic [15:0] mh2 [4];
   logic [15:0] mh3 [4];
   logic [15:0] xin, expy;
   int          kcnt [4];
   int          last_acc, n, ech;
   bit          seen;

   initial begin
      bus.en = 1'b1; bus.ch_valid = 4'hF; bus.ch_data = '0;
      bus.coef_wr = 1'b0; bus.b0_in = '0; bus.b1_in = '0;
      imp_in  = '{16'd16, 16'd0, 16'd0, 16'd0, 16'd0};
      imp_exp = '{16'd16, 16'd32, 16'd32, 16'd16, 16'd0};

      // reset state, rst overriding en and valid
      tick();
      #1;
      check("rst_ready", 32'(bus.ch_ready), 32'd0);
      tick();
      check("rst_y_valid", 32'(bus.y_valid), 32'd0);
      check("rst_y_data", 32'(bus.y_data), 32'd0);
      check("rst_y_ch", 32'(bus.y_ch), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      bus.ch_valid = '0;
      rst = 1'b0;
      tick();

      // impulse on ch0
      set_coef(16'd16, 16'd32);
      for (int k = 0; k < 5; k++) begin
         do_pass(0, imp_in[k], 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
         check("imp_y", 32'(y), 32'(imp_exp[k]));
         check("imp_ch", 32'(ych), 32'd0);
         check("imp_lat", 32'(lat), 32'd5);
         if (k == 0) begin
            tick();
            check("one_cycle_valid", 32'(bus.y_valid), 32'd0);
            check("y_hold", 32'(bus.y_data), 32'd16);
            check("idle_busy", 32'(bus.busy), 32'd0);
         end
      end

      // truncation on untouched ch1
      set_coef(16'hFFFF, 16'hFFFF);
      do_pass(1, 16'hFFFF, 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("trunc_y", 32'(y), 32'hE000);
      check("trunc_ch", 32'(ych), 32'd1);

      // round robin with all channels requesting
      do_reset();
      set_coef(16'd3, 16'd5);
      for (int c = 0; c < 4; c++) begin
         mh1[c] = '0; mh2[c] = '0; mh3[c] = '0; kcnt[c] = 0;
         bus.ch_data[c*16 +: 16] = 16'(1000 + c * 100);
      end
      bus.ch_valid = 4'hF;
      last_acc = 0;
      for (int p = 0; p < 6; p++) begin
         ech = p % 4;
         #1;
         check("rr_ready", 32'(bus.ch_ready), 32'(1 << ech));
         if (p > 0) check("rr_spacing", 32'(cyc - last_acc), 32'd5);
         last_acc = cyc;
         xin  = bus.ch_data[ech*16 +: 16];
         expy = fir(xin, mh1[ech], mh2[ech], mh3[ech], 16'd3, 16'd5);
         mh3[ech] = mh2[ech]; mh2[ech] = mh1[ech]; mh1[ech] = xin;
         tick();
         kcnt[ech]++;
         bus.ch_data[ech*16 +: 16] = 16'(1000 + ech * 100 + kcnt[ech] * 37);
         n = 1;
         while (!bus.y_valid && n < 20) begin
            tick();
            n++;
         end
         check("rr_valid", 32'(bus.y_valid), 32'd1);
         check("rr_y", 32'(bus.y_data), 32'(expy));
         check("rr_ch", 32'(bus.y_ch), 32'(ech));
      end
      bus.ch_valid = '0;

      // coefficient timing
      do_reset();
      set_coef(16'd16, 16'd0);
      do_pass(0, 16'd16, 0, 1'b0, 1'b1, 16'd32, 16'd0, y, ych, lat);
      check("coef_mid_A", 32'(y), 32'd16);
      do_pass(0, 16'd16, 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("coef_B", 32'(y), 32'd32);
      do_pass(0, 16'd16, 0, 1'b1, 1'b0, 16'd48, 16'd0, y, ych, lat);
      check("coef_coinc_C", 32'(y), 32'd32);
      do_pass(0, 16'd0, 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("coef_next_D", 32'(y), 32'd48);

      // en stall vs no stall on fresh channels
      do_pass(2, 16'd100, 3, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("stall_y", 32'(y), 32'd300);
      check("stall_lat", 32'(lat), 32'd8);
      check("stall_ch", 32'(ych), 32'd2);
      do_pass(3, 16'd100, 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("nostall_y", 32'(y), 32'd300);
      check("nostall_lat", 32'(lat), 32'd5);

      // reset in tap 2 of a ch1 pass
      set_coef(16'd16, 16'd32);
      bus.ch_valid = 4'b0010;
      bus.ch_data[16 +: 16] = 16'd500;
      tick();
      bus.ch_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      seen = bus.y_valid;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | bus.y_valid;
      end
      check("rstmid_no_valid", 32'(seen), 32'd0);
      set_coef(16'd16, 16'd32);
      bus.ch_valid = 4'hF;
      bus.ch_data = '0;
      bus.ch_data[15:0] = 16'd16;
      #1;
      check("rstmid_rr0", 32'(bus.ch_ready), 32'd1);
      bus.ch_valid = '0;
      do_pass(0, 16'd16, 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("rstmid_imp", 32'(y), 32'd16);
      do_pass(1, 16'd0, 0, 1'b0, 1'b0, 16'd0, 16'd0, y, ych, lat);
      check("rstmid_ch1_hist", 32'(y), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
